// File: rtl/stream_demux_4bit_pkg.sv
// Shared defaults, channel indices and routing-mode encodings for the
// two-channel stream demultiplexer.
package stream_demux_4bit_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_idx_t;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_demux_4bit_chan_buf.sv
// One output channel: a single-entry skid-free buffer plus a saturating
// count of completed output handshakes.
module demux_chan_buf
    import stream_demux_4bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain_s;

    assign drain_s = valid_q & out_ready;

    // Next-state for buffer contents and handshake counter; a load wins over
    // a drain so the slot refills in the same cycle without a bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (clr) begin
            cnt_d = '0;
        end else if (drain_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/stream_demux_4bit.sv
// Routes an input stream to one of two buffered channels, either by an
// explicit select or by alternating round-robin on accepted words.
module stream_demux_4bit
    import stream_demux_4bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             mode,
    input  logic             clr,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic             out0_valid,
    output logic             out1_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    ch_idx_t target_s;
    ch_idx_t rr_q, rr_d;
    logic    accept_s;
    logic    load0_s, load1_s;

    // Destination and readiness of that destination, both combinational.
    always_comb begin
        target_s = CH0;
        in_ready = 1'b1;
        if (mode == MODE_RR) begin
            target_s = rr_q;
        end else begin
            target_s = ch_idx_t'(sel);
        end
        if (target_s == CH1) begin
            in_ready = ~out1_valid | out1_ready;
        end else begin
            in_ready = ~out0_valid | out0_ready;
        end
    end

    assign accept_s = in_valid & in_ready;
    assign load0_s  = accept_s & (target_s == CH0);
    assign load1_s  = accept_s & (target_s == CH1);

    // Pointer moves only on accepted round-robin words; it is kept across mode changes.
    always_comb begin
        rr_d = rr_q;
        if ((mode == MODE_RR) && accept_s) begin
            rr_d = (rr_q == CH0) ? CH1 : CH0;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= CH0;
        end else begin
            rr_q <= rr_d;
        end
    end

    demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan0 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .load      (load0_s),
        .load_data (in_data),
        .out_data  (out0_data),
        .out_valid (out0_valid),
        .out_ready (out0_ready),
        .cnt       (cnt0)
    );

    demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan1 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .load      (load1_s),
        .load_data (in_data),
        .out_data  (out1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .cnt       (cnt1)
    );

endmodule

// File: doc/stream_demux_4bit.md
STREAM_DEMUX_4BIT -- requirements
Module: stream_demux_4bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter WIDTH, default 4: data width of the input and each output channel.
REQ-003 Parameter CNT_W, default 8: width of each per-channel transfer counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 in_valid  input  1  input word present.
REQ-008 in_ready  output  1  block accepts the input word this cycle.
REQ-009 sel  input  1  explicit destination in mode 0: 0 routes to channel 0, 1 routes to channel 1.
REQ-010 mode  input  1  0 = explicit sel; 1 = round-robin alternation.
REQ-011 clr  input  1  synchronous clear of both counters.
REQ-012 out0_data, out1_data  output  WIDTH  channel data.
REQ-013 out0_valid, out1_valid  output  1  channel word present.
REQ-014 out0_ready, out1_ready  input  1  channel sink accepts the word.
REQ-015 cnt0, cnt1  output  CNT_W  completed output handshakes per channel.

Function
REQ-016 target SHALL equal sel when mode=0 and rr_ptr when mode=1, evaluated combinationally in the same cycle.
REQ-017 Each channel SHALL hold a one-entry buffer (data register plus valid flag).
REQ-018 in_ready SHALL equal (NOT outN_valid) OR outN_ready for N=target, with no dependence on in_valid.
REQ-019 An input transfer occurs when in_valid AND in_ready; in_data is written to the target buffer, and outN_valid is 1 at the next edge (1-cycle latency).
REQ-020 An output transfer occurs when outN_valid AND outN_ready; with no load in the same cycle, outN_valid clears at the next edge.
REQ-021 A load and a drain on the same channel in the same cycle SHALL overwrite the buffer with the new word, keep outN_valid=1, and cause no bubble and no loss.
REQ-022 While outN_valid=1 and outN_ready=0, outN_data SHALL be held stable.
REQ-023 The non-target channel SHALL be unaffected by input activity and SHALL drain independently.
REQ-024 rr_ptr SHALL toggle only on an accepted input transfer while mode=1; a stall SHALL not advance it, and it SHALL hold its value in mode 0.
REQ-025 Switching mode between words takes effect in the same cycle; rr_ptr SHALL retain its value across mode changes.
REQ-026 cntN SHALL increment on each output transfer of channel N and saturate at 2^CNT_W-1.
REQ-027 clr SHALL zero both counters at the next edge and takes priority over a same-cycle increment.
REQ-028 outN_data SHALL not change while outN_valid=0, except on a load.

Reset
REQ-029 While reset=1: out0_valid=out1_valid=0, out0_data=out1_data=0, rr_ptr=0, cnt0=cnt1=0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered words with no output handshake and no counter increment.
REQ-031 in_ready SHALL be 1 during and after reset, since both buffers are empty.

Structure
REQ-032 The shared package SHALL hold the WIDTH and CNT_W defaults, a channel-index typedef (CH0, CH1) and the mode constants (MODE_SEL, MODE_RR).
REQ-033 The per-channel buffer and counter SHALL be one sub-module, demux_chan_buf, instantiated twice.
REQ-034 The top level SHALL contain only the target select, the in_ready mux and rr_ptr.

Verification
REQ-035 mode=0, sel=0, in_data=4'hA valid for 1 cycle, out0_ready=1 -> out0_data=4'hA and out0_valid=1 the next cycle; out1_valid stays 0; cnt0=1.
REQ-036 mode=1, words 1,2,3,4 back-to-back, both readys=1 -> channel 0 receives 1,3 and channel 1 receives 2,4; in_ready stays 1; cnt0=cnt1=2.
REQ-037 mode=0, sel=1, out1_ready=0, two words 5 then 6 -> 5 is accepted, then in_ready=0 and out1_data holds 5; when out1_ready=1, 5 drains and 6 loads in the same cycle with no bubble.
REQ-038 mode=1 with channel 0 stalled -> rr_ptr does not advance while in_ready=0; after the stall, the next word goes to channel 0.
REQ-039 CNT_W=8, 260 drains on channel 0 -> cnt0=255; clr=1 together with a drain -> cnt0=0.
REQ-040 reset pulse while out0_valid=1 with data 4'h7 -> out0_valid=0, out0_data=0, cnt0 unchanged from 0, rr_ptr=0.
